// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared types and width helper for the multi-channel biquad IIR
package iir_pkg;

    typedef enum logic [2:0] {B0, B1, B2, A1, A2} coef_idx_e;

    typedef enum logic [1:0] {IDLE, MAC, WB, OUT} state_e;

    // Headroom of 3 bits covers the sum of five full-scale products.
    function automatic int acc_w(input int dw, input int coefw);
        return dw + coefw + 3;
    endfunction

endpackage

// File: rtl/iir_round_sat.sv
// rtl/iir_round_sat.sv - combinational round-half-up and saturate from Q-fraction accumulator
module iir_round_sat #(
    parameter int IW = 45,
    parameter int OW = 24,
    parameter int Q  = 16
) (
    input  logic signed [IW-1:0] din,
    output logic signed [OW-1:0] dout,
    output logic                 clip
);

    localparam logic signed [IW-1:0] RND  = {{(IW-Q){1'b0}}, 1'b1, {(Q-1){1'b0}}};
    localparam logic signed [IW-1:0] MAXV = {{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [IW-1:0] MINV = {{(IW-OW+1){1'b1}}, {(OW-1){1'b0}}};

    logic signed [IW-1:0] rnd;
    logic signed [IW-1:0] shf;

    always_comb begin
        rnd  = din + RND;
        shf  = rnd >>> Q;
        clip = 1'b0;
        dout = shf[OW-1:0];
        if (shf > MAXV) begin
            dout = MAXV[OW-1:0];
            clip = 1'b1;
        end else if (shf < MINV) begin
            dout = MINV[OW-1:0];
            clip = 1'b1;
        end
    end

endmodule

// File: rtl/iir_biquad_mc.sv
// rtl/iir_biquad_mc.sv - multi-channel cascaded DF-I biquad, one shared MAC; optional IIR_SAT_STATUS_EN
module iir_biquad_mc
    import iir_pkg::*;
#(
    parameter int  DW    = 24,
    parameter int  COEFW = 18,
    parameter int  COEFQ = 16,
    parameter int  NSEC  = 1,
    parameter int  NCH   = 2,
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DW-1:0]           s_axis_tdata,
    input  logic [CHW-1:0]          s_axis_tid,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [DW-1:0]           m_axis_tdata,
    output logic [CHW-1:0]          m_axis_tid,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    input  logic [NSEC*5*COEFW-1:0] coefs
`ifdef IIR_SAT_STATUS_EN
    ,
    output logic                    sat_flag,
    input  logic                    sat_clr
`endif
);

    localparam int AW    = acc_w(DW, COEFW);
    localparam int PW    = DW + COEFW;
    localparam int SECW  = (NSEC > 1) ? $clog2(NSEC) : 1;
    localparam int DEPTH = NCH * NSEC;
    localparam int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NCOEF = NSEC * 5;
    localparam int CIXW  = $clog2(NCOEF);

    state_e                  state_q, state_d;
    logic                    rdy_q, rdy_d;
    logic [SECW-1:0]         sec_q, sec_d;
    coef_idx_e               k_q, k_d;
    logic signed [AW-1:0]    acc_q, acc_d;
    logic signed [DW-1:0]    xin_q, xin_d;
    logic [CHW-1:0]          tid_q, tid_d;
    logic signed [DW-1:0]    out_q, out_d;
    logic signed [COEFW-1:0] coef_q [NCOEF];
    logic signed [COEFW-1:0] coef_d [NCOEF];
    logic signed [COEFW-1:0] coef_in [NCOEF];
    logic signed [DW-1:0]    x1_q [DEPTH];
    logic signed [DW-1:0]    x1_d [DEPTH];
    logic signed [DW-1:0]    x2_q [DEPTH];
    logic signed [DW-1:0]    x2_d [DEPTH];
    logic signed [DW-1:0]    y1_q [DEPTH];
    logic signed [DW-1:0]    y1_d [DEPTH];
    logic signed [DW-1:0]    y2_q [DEPTH];
    logic signed [DW-1:0]    y2_d [DEPTH];

    logic [IDXW-1:0]         idx;
    logic [CIXW-1:0]         cix;
    logic signed [COEFW-1:0] coef_sel;
    logic signed [DW-1:0]    opnd;
    logic signed [PW-1:0]    prod;
    logic signed [AW-1:0]    prod_x;
    logic signed [DW-1:0]    res;
    logic                    clip;

    for (genvar g = 0; g < NCOEF; g++) begin : g_coef
        assign coef_in[g] = coefs[g*COEFW +: COEFW];
    end

    iir_round_sat #(.IW(AW), .OW(DW), .Q(COEFQ)) u_round_sat (
        .din  (acc_q),
        .dout (res),
        .clip (clip)
    );

    always_comb begin
        idx      = IDXW'(int'(tid_q) * NSEC + int'(sec_q));
        cix      = CIXW'(int'(sec_q) * 5 + int'(k_q));
        coef_sel = coef_q[cix];
        case (k_q)
            B0:      opnd = xin_q;
            B1:      opnd = x1_q[idx];
            B2:      opnd = x2_q[idx];
            A1:      opnd = y1_q[idx];
            A2:      opnd = y2_q[idx];
            default: opnd = '0;
        endcase
        prod   = coef_sel * opnd;
        prod_x = {{(AW-PW){prod[PW-1]}}, prod};
    end

    always_comb begin
        state_d = state_q;
        rdy_d   = 1'b1;
        sec_d   = sec_q;
        k_d     = k_q;
        acc_d   = acc_q;
        xin_d   = xin_q;
        tid_d   = tid_q;
        out_d   = out_q;
        coef_d  = coef_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        y1_d    = y1_q;
        y2_d    = y2_q;
        case (state_q)
            IDLE: begin
                // Out-of-range channel IDs are consumed here without leaving IDLE.
                if (rdy_q && s_axis_tvalid && int'(s_axis_tid) < NCH) begin
                    xin_d   = s_axis_tdata;
                    tid_d   = s_axis_tid;
                    coef_d  = coef_in;
                    acc_d   = '0;
                    sec_d   = '0;
                    k_d     = B0;
                    state_d = MAC;
                end
            end
            MAC: begin
                if (k_q == A1 || k_q == A2) begin
                    acc_d = acc_q - prod_x;
                end else begin
                    acc_d = acc_q + prod_x;
                end
                if (k_q == A2) begin
                    state_d = WB;
                end else begin
                    k_d = coef_idx_e'(k_q + 3'd1);
                end
            end
            WB: begin
                x2_d[idx] = x1_q[idx];
                x1_d[idx] = xin_q;
                y2_d[idx] = y1_q[idx];
                y1_d[idx] = res;
                xin_d     = res;
                acc_d     = '0;
                k_d       = B0;
                if (sec_q == SECW'(NSEC - 1)) begin
                    out_d   = res;
                    state_d = OUT;
                end else begin
                    sec_d   = sec_q + SECW'(1);
                    state_d = MAC;
                end
            end
            OUT: begin
                if (m_axis_tready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            sec_q   <= '0;
            k_q     <= B0;
            acc_q   <= '0;
            xin_q   <= '0;
            tid_q   <= '0;
            out_q   <= '0;
            coef_q  <= '{default: '0};
            x1_q    <= '{default: '0};
            x2_q    <= '{default: '0};
            y1_q    <= '{default: '0};
            y2_q    <= '{default: '0};
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            sec_q   <= sec_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            xin_q   <= xin_d;
            tid_q   <= tid_d;
            out_q   <= out_d;
            coef_q  <= coef_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            y1_q    <= y1_d;
            y2_q    <= y2_d;
        end
    end

    assign s_axis_tready = rdy_q && (state_q == IDLE);
    assign m_axis_tvalid = (state_q == OUT);
    assign m_axis_tdata  = out_q;
    assign m_axis_tid    = tid_q;

`ifdef IIR_SAT_STATUS_EN
    logic sat_q, sat_d;

    always_comb begin
        sat_d = sat_q;
        if (sat_clr) begin
            sat_d = 1'b0;
        end
        if (state_q == WB && clip) begin
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat_flag = sat_q;
`else
    logic unused_clip;
    assign unused_clip = clip;
`endif

endmodule

// File: tb/tb_iir_biquad_mc.sv
// tb/tb_iir_biquad_mc.sv - scoreboard bench for iir_biquad_mc (NSEC=1, NCH=3)
module tb_iir_biquad_mc;

    typedef struct {
        int data;
        int tid;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] s_tdata = '0;
    logic [1:0]  s_tid = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [23:0] m_tdata;
    logic [1:0]  m_tid;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic [89:0] coefs = '0;
`ifdef IIR_SAT_STATUS_EN
    logic        sat_flag;
    logic        sat_clr = 1'b0;
`endif

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    iir_biquad_mc #(.DW(24), .COEFW(18), .COEFQ(16), .NSEC(1), .NCH(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tid    (s_tid),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tid    (m_tid),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .coefs         (coefs)
`ifdef IIR_SAT_STATUS_EN
        ,
        .sat_flag      (sat_flag),
        .sat_clr       (sat_clr)
`endif
    );

    always #5 clk = ~clk;

    task automatic set_coefs(input int b0, input int b1, input int b2, input int a1, input int a2);
        coefs = {18'(a2), 18'(a1), 18'(b2), 18'(b1), 18'(b0)};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sb.delete();
    endtask

    // Drive one sample; returns after the accepting edge. Expected output pushed when push=1.
    task automatic send(input int ch, input int x, input int exp_y, input bit push, output bit ok);
        exp_t e;
        @(negedge clk);
        s_tdata  = 24'(x);
        s_tid    = 2'(ch);
        s_tvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (s_tready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        if (push) begin
            e.data = exp_y;
            e.tid  = ch;
            sb.push_back(e);
        end
    endtask

    task automatic get_out(output int d, output int id, output int lat, output bit got);
        got = 1'b0;
        lat = 0;
        d   = 0;
        id  = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (m_tvalid) begin
                got = 1'b1;
                d   = int'($signed(m_tdata));
                id  = int'(m_tid);
                break;
            end
        end
    endtask

    task automatic test_reset();
        tests++;
        if (s_tready !== 1'b0) begin fails++; $display("FAIL reset_tready: got %b expected 0", s_tready); end
        tests++;
        if (m_tvalid !== 1'b0) begin fails++; $display("FAIL reset_tvalid: got %b expected 0", m_tvalid); end
        tests++;
        if (m_tdata !== 24'd0 || m_tid !== 2'd0) begin
            fails++; $display("FAIL reset_out: got data %0d tid %0d expected 0 0", m_tdata, m_tid);
        end
`ifdef IIR_SAT_STATUS_EN
        tests++;
        if (sat_flag !== 1'b0) begin fails++; $display("FAIL reset_sat: got %b expected 0", sat_flag); end
`endif
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (s_tready !== 1'b1) begin fails++; $display("FAIL release_tready: got %b expected 1", s_tready); end
    endtask

    task automatic run_seq(input string name, input int chs[], input int xs[], input int ys[]);
        bit ok, got;
        int d, id, lat;
        exp_t e;
        for (int i = 0; i < xs.size(); i++) begin
            send(chs[i], xs[i], ys[i], 1'b1, ok);
            get_out(d, id, lat, got);
            e = sb.pop_front();
            tests++;
            if (!ok || !got || d !== e.data || id !== e.tid) begin
                fails++;
                $display("FAIL %s[%0d]: got data %0d tid %0d (acc %0b out %0b) expected data %0d tid %0d",
                         name, i, d, id, ok, got, e.data, e.tid);
            end
        end
    endtask

    task automatic test_unity();
        bit ok, got;
        int d, id, lat;
        exp_t e;
        do_reset();
        set_coefs(65536, 0, 0, 0, 0);
        send(0, 1000, 1000, 1'b1, ok);
        get_out(d, id, lat, got);
        e = sb.pop_front();
        tests++;
        if (!got || d !== e.data || id !== e.tid) begin
            fails++; $display("FAIL unity_1000: got %0d tid %0d expected %0d tid %0d", d, id, e.data, e.tid);
        end
        tests++;
        if (lat !== 7) begin fails++; $display("FAIL unity_latency: got %0d expected 7", lat); end
        run_seq("unity_neg", '{0}, '{-1}, '{-1});
    endtask

    task automatic test_decay();
        do_reset();
        set_coefs(65536, 0, 0, -32768, 0);
        run_seq("decay", '{0, 0, 0, 0}, '{4096, 0, 0, 0}, '{4096, 2048, 1024, 512});
    endtask

    task automatic test_channels();
        do_reset();
        set_coefs(65536, 0, 0, -32768, 0);
        run_seq("channels", '{0, 1, 0, 1, 0, 1}, '{4096, 0, 0, 0, 0, 0}, '{4096, 0, 2048, 0, 1024, 0});
    endtask

    task automatic test_saturation();
        do_reset();
        set_coefs(130000, 0, 0, 0, 0);
        run_seq("saturate", '{2, 2}, '{6000000, -6000000}, '{8388607, -8388608});
`ifdef IIR_SAT_STATUS_EN
        tests++;
        if (sat_flag !== 1'b1) begin fails++; $display("FAIL sat_flag_set: got %b expected 1", sat_flag); end
        @(negedge clk);
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        tests++;
        if (sat_flag !== 1'b0) begin fails++; $display("FAIL sat_flag_clr: got %b expected 0", sat_flag); end
`endif
    endtask

    task automatic test_backpressure();
        bit ok, got, seen;
        int d, id, lat;
        exp_t e;
        do_reset();
        set_coefs(65536, 0, 0, 0, 0);
        m_tready = 1'b0;
        send(1, 500, 500, 1'b1, ok);
        get_out(d, id, lat, got);
        e = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests++;
            if (m_tvalid !== 1'b1 || int'($signed(m_tdata)) !== e.data || int'(m_tid) !== e.tid || s_tready !== 1'b0) begin
                fails++;
                $display("FAIL stall[%0d]: got valid %b data %0d tid %0d s_ready %b expected 1 %0d %0d 0",
                         i, m_tvalid, $signed(m_tdata), m_tid, s_tready, e.data, e.tid);
            end
        end
        m_tready = 1'b1;
        @(negedge clk);
        tests++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
            fails++; $display("FAIL stall_release: got valid %b s_ready %b expected 0 1", m_tvalid, s_tready);
        end
        send(3, 777, 0, 1'b0, ok);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_tvalid) seen = 1'b1;
        end
        tests++;
        if (!ok || seen !== 1'b0 || s_tready !== 1'b1) begin
            fails++; $display("FAIL bad_tid: got accepted %b output %b s_ready %b expected 1 0 1", ok, seen, s_tready);
        end
        run_seq("after_bad_tid", '{1}, '{123}, '{123});
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        set_coefs(65536, 0, 0, -32768, 0);
        run_seq("pre_abort", '{0}, '{4096}, '{4096});
        send(0, 0, 2048, 1'b1, ok);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin
            fails++; $display("FAIL abort: got valid %b s_ready %b expected 0 0", m_tvalid, s_tready);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_seq("post_abort", '{0, 0}, '{4096, 0}, '{4096, 2048});
    endtask

    initial begin
        #2;
        test_reset();
        test_unity();
        test_decay();
        test_channels();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
